// File: rtl/dmem_arb_pkg.sv
// dmem_arbiter shared types and defaults.
// FSM states, port identifiers and default sizing.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_RD_LAT = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant.
// Combinational grant, registered last-grant pointer.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       upd,
    output logic [1:0] gnt
);

    logic last;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == PORT_DBG) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Pointer starts at dbg so the CPU wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last <= PORT_DBG;
        end else if (upd && (|req)) begin
            last <= gnt[1];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data BRAM between the CPU and the debug/loader port.
// One access in flight; all outputs registered.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [31:0]       dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_t            state;
    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              g_id;
    logic              l_we;
    logic [1:0]        cnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              unused_hi;

    assign req       = {dbg_req, cpu_req};
    assign sel_we    = gnt[1] ? dbg_we : cpu_we;
    assign sel_addr  = gnt[1] ? dbg_addr[ADDR_W-1:0]
                              : cpu_addr[ADDR_W-1:0];
    assign sel_wdata = gnt[1] ? dbg_wdata : cpu_wdata;
    assign unused_hi = &{1'b0, cpu_addr[31:ADDR_W],
                         dbg_addr[31:ADDR_W]};

    rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .upd     (state == IDLE),
        .gnt     (gnt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            g_id      <= PORT_CPU;
            l_we      <= 1'b0;
            cnt       <= 2'd0;
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
            dbg_ack   <= 1'b0;
            dbg_rdata <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            dbg_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        g_id      <= gnt[1];
                        l_we      <= sel_we;
                        mem_en    <= 1'b1;
                        mem_we    <= sel_we;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    if (l_we) begin
                        cpu_ack <= (g_id == PORT_CPU);
                        dbg_ack <= (g_id == PORT_DBG);
                        state   <= ACK;
                    end else begin
                        cnt   <= 2'(RD_LAT - 1);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // mem_addr is held so late input changes stay invisible
                    if (cnt == 2'd0) begin
                        if (g_id == PORT_DBG) begin
                            dbg_rdata <= mem_rdata;
                            dbg_ack   <= 1'b1;
                        end else begin
                            cpu_rdata <= mem_rdata;
                            cpu_ack   <= 1'b1;
                        end
                        state <= ACK;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                ACK: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized
// run against a cycle-count reference model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    always #5 clk = ~clk;

    logic        cpu_req, cpu_we, cpu_ack;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dbg_req, dbg_we, dbg_ack;
    logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic        mem_en, mem_we, busy;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic        c2_req, c2_we, c2_ack, d2_ack;
    logic [31:0] c2_addr, c2_wdata, c2_rdata, d2_rdata;
    logic        m2_en, m2_we, busy2;
    logic [9:0]  m2_addr;
    logic [31:0] m2_wdata, m2_rdata, p2;

    logic [31:0] bram1 [1024];
    logic [31:0] bram2 [1024];
    logic [31:0] ref_mem [1024];

    int errors = 0;
    int checks = 0;

    dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .RD_LAT(1)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack),
        .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .RD_LAT(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(c2_req), .cpu_we(c2_we), .cpu_addr(c2_addr),
        .cpu_wdata(c2_wdata), .cpu_ack(c2_ack),
        .cpu_rdata(c2_rdata),
        .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(32'd0),
        .dbg_wdata(32'd0), .dbg_ack(d2_ack),
        .dbg_rdata(d2_rdata),
        .mem_en(m2_en), .mem_we(m2_we), .mem_addr(m2_addr),
        .mem_wdata(m2_wdata), .mem_rdata(m2_rdata), .busy(busy2)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) bram1[mem_addr] <= mem_wdata;
            else        mem_rdata <= bram1[mem_addr];
        end
    end

    always @(posedge clk) begin
        if (m2_en) begin
            if (m2_we) bram2[m2_addr] <= m2_wdata;
            else       p2 <= bram2[m2_addr];
        end
        m2_rdata <= p2;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not end");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Waits for the selected ack; lat = -1 on timeout.
    task automatic wait_ack(input int sel, output int lat,
                            output int wecnt);
        lat = -1;
        wecnt = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (sel == 2 ? m2_we : mem_we) wecnt++;
            if ((sel == 0 && cpu_ack) || (sel == 1 && dbg_ack) ||
                (sel == 2 && c2_ack)) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        logic [99:0] o1, o2;
        reset_n = 1'b0;
        {cpu_req, cpu_we, dbg_req, dbg_we, c2_req, c2_we} = '0;
        {cpu_addr, cpu_wdata, dbg_addr, dbg_wdata} = '0;
        {c2_addr, c2_wdata} = '0;
        repeat (3) tick();
        o1 = {cpu_ack, cpu_rdata, dbg_ack, dbg_rdata, mem_en};
        o2 = {mem_we, mem_addr, mem_wdata, busy};
        checks++;
        if (o1 !== '0 || o2 !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h %h want 0", o1, o2);
        end
        o1 = {c2_ack, c2_rdata, d2_ack, d2_rdata, m2_en};
        o2 = {m2_we, m2_addr, m2_wdata, busy2};
        checks++;
        if (o1 !== '0 || o2 !== '0) begin
            errors++;
            $display("FAIL reset_outputs2: got %h %h want 0", o1, o2);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_write_read;
        int lat, wc;
        cpu_req = 1; cpu_we = 1;
        cpu_addr = 32'h004; cpu_wdata = 32'hDEADBEEF;
        wait_ack(0, lat, wc);
        cpu_req = 0;
        checks++;
        if (lat !== 2 || wc !== 1) begin
            errors++;
            $display("FAIL wr_latency: lat=%0d we_cycles=%0d want 2/1",
                     lat, wc);
        end
        checks++;
        if (cpu_rdata !== 32'h0) begin
            errors++;
            $display("FAIL wr_rdata_keep: got %h want 0", cpu_rdata);
        end
        tick();
        cpu_req = 1; cpu_we = 0;
        wait_ack(0, lat, wc);
        cpu_req = 0;
        checks++;
        if (lat !== 3 || wc !== 0) begin
            errors++;
            $display("FAIL rd_latency: lat=%0d we_cycles=%0d want 3/0",
                     lat, wc);
        end
        checks++;
        if (cpu_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rd_data: got %h want deadbeef", cpu_rdata);
        end
        tick();
    endtask

    task automatic test_contention;
        int lat, wc, first, k;
        int ord[$];
        bit rc, rd;
        do_reset();
        cpu_req = 1; cpu_we = 1;
        cpu_addr = 32'h008; cpu_wdata = 32'hA5A50001;
        dbg_req = 1; dbg_we = 1;
        dbg_addr = 32'h00C; dbg_wdata = 32'h5A5A0002;
        first = -1;
        for (k = 1; k <= 30; k++) begin
            tick();
            if (cpu_ack || dbg_ack) begin
                first = cpu_ack ? 0 : 1;
                break;
            end
        end
        cpu_req = 0;
        checks++;
        if (first !== 0 || k !== 2 || dbg_ack !== 1'b0) begin
            errors++;
            $display("FAIL tie_first: port=%0d lat=%0d want 0/2",
                     first, k);
        end
        wait_ack(1, lat, wc);
        dbg_req = 0;
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL tie_second: lat=%0d want 3", lat);
        end
        tick();
        cpu_we = 0; dbg_we = 0;
        cpu_req = 1; dbg_req = 1;
        rc = 0; rd = 0;
        for (int n = 0; n < 80 && ord.size() < 4; n++) begin
            tick();
            if (rc) cpu_req = 1;
            if (rd) dbg_req = 1;
            rc = 0; rd = 0;
            if (cpu_ack) begin
                ord.push_back(0); cpu_req = 0; rc = 1;
            end
            if (dbg_ack) begin
                ord.push_back(1); dbg_req = 0; rd = 1;
            end
        end
        cpu_req = 0; dbg_req = 0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= ord.size() || ord[i] !== (i % 2)) begin
                errors++;
                $display("FAIL alternate[%0d]: got %0d want %0d", i,
                         (i < ord.size()) ? ord[i] : -1, i % 2);
            end
        end
        checks++;
        if (cpu_rdata !== 32'hA5A50001 || dbg_rdata !== 32'h5A5A0002)
        begin
            errors++;
            $display("FAIL alternate_data: got %h %h", cpu_rdata,
                     dbg_rdata);
        end
        tick();
    endtask

    task automatic test_wrap;
        int lat, wc;
        dbg_req = 1; dbg_we = 1;
        dbg_addr = 32'h0000_0404; dbg_wdata = 32'h12345678;
        wait_ack(1, lat, wc);
        dbg_req = 0;
        checks++;
        if (lat !== 2 || dbg_rdata !== 32'h5A5A0002) begin
            errors++;
            $display("FAIL wrap_write: lat=%0d rdata=%h", lat,
                     dbg_rdata);
        end
        tick();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h004;
        wait_ack(0, lat, wc);
        cpu_req = 0;
        checks++;
        if (lat !== 3 || cpu_rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL wrap_read: lat=%0d got %h want 12345678",
                     lat, cpu_rdata);
        end
        tick();
    endtask

    task automatic test_rdlat2;
        int lat, wc;
        c2_req = 1; c2_we = 1;
        c2_addr = 32'h010; c2_wdata = 32'hCAFEF00D;
        wait_ack(2, lat, wc);
        c2_req = 0;
        tick();
        c2_req = 1; c2_addr = 32'h020; c2_wdata = 32'h0BAD0BAD;
        wait_ack(2, lat, wc);
        c2_req = 0;
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL rl2_write: lat=%0d want 2", lat);
        end
        tick();
        c2_req = 1; c2_we = 0; c2_addr = 32'h010;
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 2) begin
                c2_addr = 32'h020;
                c2_wdata = $urandom;
            end
            if (k == 2 || k == 3) begin
                checks++;
                if (m2_addr !== 10'h010 || m2_en !== 1'b0) begin
                    errors++;
                    $display("FAIL rl2_wait_addr: addr=%h en=%b", m2_addr,
                             m2_en);
                end
            end
            if (c2_ack) begin
                lat = k;
                break;
            end
        end
        c2_req = 0;
        checks++;
        if (lat !== 4 || c2_rdata !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL rl2_read: lat=%0d got %h want cafef00d",
                     lat, c2_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        int lat, wc, first, k;
        cpu_req = 1; cpu_we = 1;
        cpu_addr = 32'h030; cpu_wdata = 32'h11112222;
        tick();
        checks++;
        if (mem_we !== 1'b1) begin
            errors++;
            $display("FAIL mid_issue: mem_we=%b want 1", mem_we);
        end
        reset_n = 0;
        #1;
        checks++;
        if ({mem_we, mem_en, cpu_ack, cpu_rdata, dbg_rdata, busy,
             mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL mid_async: mem_we=%b en=%b busy=%b", mem_we,
                     mem_en, busy);
        end
        cpu_req = 0;
        tick();
        reset_n = 1;
        for (int n = 0; n < 4; n++) begin
            tick();
            checks++;
            if (cpu_ack !== 1'b0 || dbg_ack !== 1'b0) begin
                errors++;
                $display("FAIL mid_no_ack: cpu=%b dbg=%b", cpu_ack,
                         dbg_ack);
            end
        end
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h004;
        dbg_req = 1; dbg_we = 0; dbg_addr = 32'h404;
        first = -1;
        for (k = 1; k <= 30; k++) begin
            tick();
            if (cpu_ack || dbg_ack) begin
                first = cpu_ack ? 0 : 1;
                break;
            end
        end
        cpu_req = 0;
        checks++;
        if (first !== 0 || k !== 3 || cpu_rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL mid_tie: port=%0d lat=%0d data=%h", first, k,
                     cpu_rdata);
        end
        wait_ack(1, lat, wc);
        dbg_req = 0;
        checks++;
        if (lat !== 4 || dbg_rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL mid_tie2: lat=%0d data=%h", lat, dbg_rdata);
        end
        tick();
    endtask

    task automatic test_random;
        int lat, wc, g, nxt, last, g_cyc, ack_cyc;
        bit act[2], justack[2], we_q[2], pend, g_we;
        bit ec, ed, een, ebusy;
        logic [31:0] addr_q[2], wd_q[2], hold[2], exp_data;
        logic [9:0] g_addr;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            dbg_req = 1; dbg_we = 1;
            dbg_addr = ($urandom & 32'hFFFFFC00) | (32'h100 + i);
            dbg_wdata = $urandom;
            ref_mem[10'h100 + 10'(i)] = dbg_wdata;
            wait_ack(1, lat, wc);
            dbg_req = 0;
            checks++;
            if (lat !== 2) begin
                errors++;
                $display("FAIL preload[%0d]: lat=%0d want 2", i, lat);
            end
            tick();
        end
        hold[0] = '0; hold[1] = '0;
        act = '{0, 0}; justack = '{0, 0};
        pend = 0; nxt = 0; last = 1;
        g_cyc = 0; ack_cyc = 0; g = 0; g_we = 0;
        g_addr = '0; exp_data = '0;
        for (int c = 0; c < 600; c++) begin
            een = pend && (c == g_cyc + 1);
            ec = pend && (c == ack_cyc) && (g == 0);
            ed = pend && (c == ack_cyc) && (g == 1);
            ebusy = pend && (c > g_cyc) && (c <= ack_cyc);
            if ((ec || ed) && !g_we) hold[g] = exp_data;
            checks++;
            if ({mem_en, mem_we, cpu_ack, dbg_ack, busy} !==
                {een, een && g_we, ec, ed, ebusy} ||
                (een && mem_addr !== g_addr)) begin
                errors++;
                $display("FAIL rnd_ctrl c=%0d: en/we/ack/busy=%b%b%b%b%b",
                         c, mem_en, mem_we, cpu_ack, dbg_ack, busy);
            end
            checks++;
            if (cpu_rdata !== hold[0] || dbg_rdata !== hold[1]) begin
                errors++;
                $display("FAIL rnd_rdata c=%0d: got %h %h want %h %h", c,
                         cpu_rdata, dbg_rdata, hold[0], hold[1]);
            end
            if (ec || ed) begin
                act[g] = 0; justack[g] = 1;
                pend = 0; nxt = c + 1;
            end
            for (int p = 0; p < 2; p++) begin
                if (justack[p]) begin
                    justack[p] = 0;
                end else if (!act[p] && $urandom_range(0, 2) == 0) begin
                    act[p] = 1;
                    we_q[p] = 1'($urandom_range(0, 1));
                    addr_q[p] = ($urandom & 32'hFFFFFC00) |
                                (32'h100 + $urandom_range(0, 15));
                    wd_q[p] = $urandom;
                end
            end
            if (pend && c > g_cyc && $urandom_range(0, 1) == 1) begin
                we_q[g] = ~we_q[g];
                addr_q[g] = $urandom;
                wd_q[g] = $urandom;
            end
            if (!pend && c >= nxt && (act[0] || act[1])) begin
                g = (act[0] && act[1]) ? 1 - last : (act[0] ? 0 : 1);
                last = g; pend = 1; g_cyc = c;
                g_we = we_q[g];
                g_addr = addr_q[g][9:0];
                ack_cyc = c + (g_we ? 2 : 3);
                if (g_we) ref_mem[g_addr] = wd_q[g];
                else      exp_data = ref_mem[g_addr];
            end
            cpu_req = act[0]; cpu_we = we_q[0];
            cpu_addr = addr_q[0]; cpu_wdata = wd_q[0];
            dbg_req = act[1]; dbg_we = we_q[1];
            dbg_addr = addr_q[1]; dbg_wdata = wd_q[1];
            tick();
        end
        cpu_req = 0; dbg_req = 0;
        repeat (6) tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_contention();
        test_wrap();
        test_rdlat2();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port access controller that shares the single-port data-memory BRAM between the CPU load/store path and the debug/program-loader port.
- Arbitrates round-robin between the two ports and drives the BRAM enable, write-enable, address and write-data.
- Covers the BRAM's registered read latency and returns read data with a one-cycle ack pulse to the requester that was granted.
- Sits between the core's memory stage, the loader, and the data BRAM instance.

Parameters:
- ADDR_W, 10, BRAM address width; only addr[ADDR_W-1:0] is used.
- DATA_W, 32, data word width.
- RD_LAT, 1, BRAM read latency in cycles; legal values are 1 and 2.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held high until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  32  byte address from the ALU result; upper bits are ignored.
- cpu_wdata  in  DATA_W  store data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  read data; valid in the cpu_ack cycle, held afterwards.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata: same as the cpu_* ports, for the debug/loader port.
- mem_en  out  1  BRAM enable.
- mem_we  out  1  BRAM write enable.
- mem_addr  out  ADDR_W  BRAM address.
- mem_wdata  out  DATA_W  BRAM write data.
- mem_rdata  in  DATA_W  BRAM read data, valid RD_LAT cycles after the enabled read cycle.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset:
  - State goes to IDLE and every output goes to 0, including both rdata registers.
  - The round-robin pointer is set to "last = dbg", so the CPU wins the first tie.
  - Reset takes effect immediately, asynchronously. A write in progress is dropped, since mem_we falls at once. No ack is issued for an aborted access.
- FSM states: IDLE, ISSUE, WAIT, ACK. All outputs are registered.
- IDLE:
  - If any req is high, grant one port and latch its we, addr[ADDR_W-1:0] and wdata into internal registers, then go to ISSUE.
  - If both reqs are high, grant the port not granted last, then update the pointer.
  - If only one req is high, grant it regardless of the pointer; the pointer is still updated.
- ISSUE:
  - Drive mem_en=1, mem_we=latched we, mem_addr and mem_wdata from the latched values, for exactly one cycle.
  - On a write, go to ACK.
  - On a read, go to WAIT and load a counter with RD_LAT-1.
- WAIT:
  - mem_en=0 and mem_we=0.
  - When the counter reaches 0, capture mem_rdata into the granted port's rdata register and go to ACK. Otherwise decrement the counter.
  - For RD_LAT=1, WAIT lasts one cycle.
- ACK:
  - Pulse the granted port's ack for one cycle.
  - rdata is already updated for reads; a write leaves rdata unchanged.
  - Always go to IDLE next.
- Latency, counted from the IDLE cycle that samples req:
  - Write: ack appears 2 cycles later.
  - Read: ack appears 2+RD_LAT cycles later.
  - Minimum spacing between successive grants is 3+RD_LAT cycles for reads and 3 for writes.
- Requester rules:
  - Drop req in the ack cycle or the cycle after it. A req still high in IDLE is treated as a new access.
  - Changes to req, we, addr or wdata while not in IDLE are ignored, because the values are latched.
- The ungranted port is stalled: its ack stays 0 and its rdata is untouched.
- Only one access is in flight at a time. mem_en and mem_we are never high outside ISSUE.
- Address bits at and above ADDR_W are ignored, so addresses wrap modulo 2^ADDR_W.
- An unused port with req tied 0 never affects timing.

Decomposition:
- Package dmem_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, ACK);
  - port-ID constants PORT_CPU=0 and PORT_DBG=1;
  - default ADDR_W, DATA_W and RD_LAT.
- One natural sub-module: rr_arb2, a combinational two-requester round-robin grant with a registered last-grant pointer and an update strobe.
- The FSM and datapath registers stay in dmem_arbiter.

Test Plan:
- Write then read, CPU only, RD_LAT=1:
  - cpu write addr=0x004, data=0xDEADBEEF gives cpu_ack 2 cycles after sampling, with mem_we high exactly one cycle.
  - cpu read addr=0x004 then gives cpu_ack 3 cycles after sampling, with cpu_rdata=0xDEADBEEF.
- Contention:
  - cpu_req and dbg_req both rise in the same cycle right after reset: CPU is granted first, then dbg.
  - Holding both requests gives grants alternating cpu, dbg, cpu, dbg.
- Address wrap: dbg writes 0x12345678 to addr=0x0000_0404; a cpu read of addr=0x004 returns 0x12345678.
- RD_LAT=2: a read ack arrives 4 cycles after sampling. Changing cpu_addr during WAIT does not alter mem_addr or the returned data.
- Reset mid-access: assert reset_n=0 in the ISSUE cycle of a write. mem_we drops immediately, no ack is issued, all outputs are 0, and the next tie grants the CPU.
- Stall isolation: during a long dbg read, cpu_ack stays 0 and cpu_rdata holds its previous value; a write ack leaves that port's rdata unchanged.
